step_profile_generator: RTL and testbench
=========================================

# step_profile_generator

Consumes the five per-axis motion parameters N, nn, t0, tna and delta produced by the parameter-calculation stage. It emits a trapezoidal step-pulse train for one stepper axis: nn accelerating steps, N−2·nn cruise steps and nn decelerating steps. A one-cycle finish pulse marks the end of the move. One instance sits per axis between parameter calculation and the stepper driver pins.

## Interface
- PULSE_W, default 4: step pulse high time in clk cycles; must be ≥1 and < MIN_PERIOD.
- MIN_PERIOD, default 8: lower clamp on any step period in clk cycles.
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  begin move; sampled only in IDLE.
- params  in  32×[0:4]  unpacked array: 0 = N, 1 = nn, 2 = t0, 3 = tna, 4 = delta; all unsigned; periods are in clk cycles.
- dir  in  1  direction; latched with start.
- step  out  1  step pulse to driver.
- dir_out  out  1  latched direction; stable for the whole move.
- busy  out  1  move in progress.
- finish  out  1  one-cycle end-of-move pulse.
- steps_done  out  32  steps issued in current/last move.

## Operation
- States: IDLE, ACCEL, CRUISE, DECEL, DONE.
- Reset values: step=0, dir_out=0, busy=0, finish=0, steps_done=0, state=IDLE.
- IDLE + start: latch all five params and dir.
  - nn_eff = min(nn, N>>1).
  - cruise_n = N − 2·nn_eff.
  - p = max(t0, MIN_PERIOD).
  - steps_done=0.
- Next state after start:
  - N=0 → DONE.
  - nn_eff=0 → CRUISE.
  - else → ACCEL.
- Each step is one period of length L cycles. step is high for the first PULSE_W cycles, then low; steps_done increments at the rising edge of step.
- ACCEL, step k (0…nn_eff−1): L=p.
  - At period end, if k<nn_eff−1: p = max(p−delta, tna, MIN_PERIOD), computed with no unsigned underflow (treat p<delta as 0 before clamping).
  - After the last accel step: p_last = p.
  - Go to CRUISE if cruise_n>0, else DECEL.
- CRUISE: cruise_n steps, each L = max(tna, MIN_PERIOD); p is untouched.
  - Then go to DECEL if nn_eff>0, else DONE.
- DECEL, step j (0…nn_eff−1): L=p. The first decel step uses p_last.
  - At period end, p = min(p+delta, max(t0, MIN_PERIOD)).
  - Use a 33-bit add so the result saturates, never wraps.
  - After nn_eff steps → DONE.
- DONE: finish=1 for exactly one cycle, busy=0, return to IDLE. steps_done holds its value until the next start.
- start while not IDLE: ignored. Param changes after start: ignored.
- Reset mid-move: step drops in the same edge; all outputs and state return to reset values; no finish pulse.

## Timing
- start is sampled at edge 0.
- busy and step rise at edge 1 (first step begins the cycle after start), for N>0.
- Periods are back-to-back with no gap cycles; the next step rises at the edge where the previous period's count reaches L.
- With ΣL = sum of all periods: busy falls and finish rises at edge 1+ΣL, and finish falls at edge 2+ΣL.
- N=0: busy stays 0; finish=1 at edge 1.
- start may be re-asserted in the cycle finish is high; it is accepted the following cycle (IDLE).
- Period counter is 32 bits. All comparisons are unsigned.

## Test plan
- N=6, nn=2, t0=100, tna=60, delta=20, PULSE_W=4 → step periods 100,80,60,60,80,100; each pulse 4 cycles wide; finish at edge 481; steps_done=6.
- N=0, start → no step, busy never high, finish single pulse at edge 1, steps_done=0.
- N=3, nn=5, t0=50, tna=20, delta=10 → nn_eff=1, cruise_n=1; periods 50,20,50; finish at edge 121.
- N=6, nn=3, t0=100, tna=20, delta=50 → accel 100,50,20 (clamped); decel 20,70,100; finish at edge 361.
- t0=3, tna=2, N=2, nn=0 → both periods clamped to MIN_PERIOD=8; finish at edge 17; second start pulse during the move is ignored.
- Reset asserted at edge 150 of the first scenario → step=0, busy=0, steps_done=0 next cycle, no finish; a fresh start then replays the full profile.

Source files
------------

// File: rtl/step_profile_generator_if.sv
// Bundles the parameter / start handshake and the step-pin outputs of one axis
// so that the parameter stage (master) and the pulse generator (slave) share one port.
interface step_profile_generator_if;
  logic        start;
  logic [31:0] params [0:4];
  logic        dir;
  logic        step;
  logic        dir_out;
  logic        busy;
  logic        finish;
  logic [31:0] steps_done;

  modport master (
    output start, params, dir,
    input  step, dir_out, busy, finish, steps_done
  );

  modport slave (
    input  start, params, dir,
    output step, dir_out, busy, finish, steps_done
  );
endinterface

// File: rtl/step_profile_generator.sv
// Trapezoidal step-pulse generator for one stepper axis: nn accelerating,
// N-2*nn cruise and nn decelerating steps, followed by a one-cycle finish pulse.
module step_profile_generator #(
  parameter int unsigned PULSE_W    = 4,
  parameter int unsigned MIN_PERIOD = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  step_profile_generator_if.slave bus
);
  localparam logic [31:0] MIN_P = 32'(MIN_PERIOD);
  localparam logic [31:0] PW    = 32'(PULSE_W);

  typedef enum logic [2:0] {IDLE, ACCEL, CRUISE, DECEL, DONE} state_t;

  state_t      state_reg;
  logic [31:0] p_reg;        // current accel/decel period
  logic [31:0] p0_reg;       // clamped t0, ceiling for deceleration
  logic [31:0] tna_c_reg;    // clamped tna: cruise period and accel floor
  logic [31:0] delta_reg;
  logic [31:0] nn_eff_reg;
  logic [31:0] cruise_n_reg;
  logic [31:0] k_reg;        // step index within the current phase
  logic [31:0] cnt_reg;      // cycles elapsed in the current period, 0 = first step pending
  logic        step_reg;
  logic        dir_reg;
  logic        busy_reg;
  logic        finish_reg;
  logic [31:0] steps_done_reg;

  // Move setup derived from the live parameter inputs, used only when start is accepted
  logic [31:0] n_in, nn_in, t0_in, tna_in, delta_in;
  logic [31:0] half_n, nn_eff_in, cruise_n_in, p0_in, tna_c_in;

  assign n_in     = bus.params[0];
  assign nn_in    = bus.params[1];
  assign t0_in    = bus.params[2];
  assign tna_in   = bus.params[3];
  assign delta_in = bus.params[4];

  assign half_n      = n_in >> 1;
  assign nn_eff_in   = (nn_in < half_n) ? nn_in : half_n;
  assign cruise_n_in = n_in - (nn_eff_in << 1);
  assign p0_in       = (t0_in > MIN_P) ? t0_in : MIN_P;
  assign tna_c_in    = (tna_in > MIN_P) ? tna_in : MIN_P;

  // Period updates: accel subtracts with floor at zero, decel adds with 33-bit saturation
  logic [31:0] p_sub, p_acc, p_dec, cur_len;
  logic [32:0] p_sum;

  assign p_sub   = (p_reg > delta_reg) ? (p_reg - delta_reg) : 32'd0;
  assign p_acc   = (p_sub > tna_c_reg) ? p_sub : tna_c_reg;
  assign p_sum   = {1'b0, p_reg} + {1'b0, delta_reg};
  assign p_dec   = (p_sum < {1'b0, p0_reg}) ? p_sum[31:0] : p0_reg;
  assign cur_len = (state_reg == CRUISE) ? tna_c_reg : p_reg;

  // Phase sequencing at the end of a period
  state_t      nxt_state;
  logic [31:0] nxt_k;
  logic        move_done;

  always_comb begin
    nxt_state = state_reg;
    nxt_k     = k_reg + 32'd1;
    move_done = 1'b0;
    case (state_reg)
      ACCEL: begin
        if (k_reg == nn_eff_reg - 32'd1) begin
          nxt_k     = 32'd0;
          nxt_state = (cruise_n_reg != 32'd0) ? CRUISE : DECEL;
        end
      end
      CRUISE: begin
        if (k_reg == cruise_n_reg - 32'd1) begin
          nxt_k = 32'd0;
          if (nn_eff_reg != 32'd0) nxt_state = DECEL;
          else                     move_done = 1'b1;
        end
      end
      DECEL: begin
        if (k_reg == nn_eff_reg - 32'd1) move_done = 1'b1;
      end
      default: begin
        nxt_state = state_reg;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      p_reg          <= 32'd0;
      p0_reg         <= 32'd0;
      tna_c_reg      <= 32'd0;
      delta_reg      <= 32'd0;
      nn_eff_reg     <= 32'd0;
      cruise_n_reg   <= 32'd0;
      k_reg          <= 32'd0;
      cnt_reg        <= 32'd0;
      step_reg       <= 1'b0;
      dir_reg        <= 1'b0;
      busy_reg       <= 1'b0;
      finish_reg     <= 1'b0;
      steps_done_reg <= 32'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          finish_reg <= 1'b0;
          if (bus.start) begin
            p_reg          <= p0_in;
            p0_reg         <= p0_in;
            tna_c_reg      <= tna_c_in;
            delta_reg      <= delta_in;
            nn_eff_reg     <= nn_eff_in;
            cruise_n_reg   <= cruise_n_in;
            dir_reg        <= bus.dir;
            k_reg          <= 32'd0;
            cnt_reg        <= 32'd0;
            steps_done_reg <= 32'd0;
            if (n_in == 32'd0)           state_reg <= DONE;
            else if (nn_eff_in == 32'd0) state_reg <= CRUISE;
            else                         state_reg <= ACCEL;
          end
        end
        ACCEL, CRUISE, DECEL: begin
          if (cnt_reg == 32'd0) begin
            step_reg       <= 1'b1;
            busy_reg       <= 1'b1;
            steps_done_reg <= steps_done_reg + 32'd1;
            cnt_reg        <= 32'd1;
          end else if (cnt_reg == cur_len) begin
            if (state_reg == ACCEL && nxt_state == ACCEL) p_reg <= p_acc;
            if (state_reg == DECEL)                       p_reg <= p_dec;
            if (move_done) begin
              state_reg  <= DONE;
              finish_reg <= 1'b1;
              busy_reg   <= 1'b0;
              step_reg   <= 1'b0;
              cnt_reg    <= 32'd0;
            end else begin
              // next period starts on this same edge: no gap between steps
              state_reg      <= nxt_state;
              k_reg          <= nxt_k;
              step_reg       <= 1'b1;
              steps_done_reg <= steps_done_reg + 32'd1;
              cnt_reg        <= 32'd1;
            end
          end else begin
            cnt_reg <= cnt_reg + 32'd1;
            if (cnt_reg == PW) step_reg <= 1'b0;
          end
        end
        DONE: begin
          // a zero-step move arrives here with finish still low and raises it one cycle later
          if (!finish_reg) begin
            finish_reg <= 1'b1;
          end else begin
            finish_reg <= 1'b0;
            state_reg  <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.step       = step_reg;
  assign bus.dir_out    = dir_reg;
  assign bus.busy       = busy_reg;
  assign bus.finish     = finish_reg;
  assign bus.steps_done = steps_done_reg;
endmodule

// File: tb/tb_step_profile_generator.sv
// Scoreboard bench: each move pushes its expected step/finish events (cycle,
// count, direction) computed from the profile rules; a negedge monitor pops and compares.
module tb_step_profile_generator;
  localparam int PULSE_W    = 4;
  localparam int MIN_PERIOD = 8;

  logic clk = 1'b0;
  logic reset;
  int unsigned cyc = 0;

  step_profile_generator_if bus();

  step_profile_generator #(.PULSE_W(PULSE_W), .MIN_PERIOD(MIN_PERIOD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_fin;
    int unsigned cyc;
    longint      sd;
    bit          d;
  } item_t;

  item_t exp_q[$];
  int    nchk  = 0;
  int    nfail = 0;
  bit    last_finished = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint lmax(input longint a, input longint b);
    return (a > b) ? a : b;
  endfunction

  // Reference profile: list of periods from the move rules, then absolute event times
  task automatic push_expected(input longint n, input longint nn, input longint t0,
                               input longint tna, input longint delta, input bit d,
                               input int unsigned e0, output longint total);
    longint per[$];
    longint ne, cn, p, top, t;
    ne  = (nn < n / 2) ? nn : n / 2;
    cn  = n - 2 * ne;
    top = lmax(t0, MIN_PERIOD);
    p   = top;
    for (longint i = 0; i < ne; i++) begin
      per.push_back(p);
      if (i < ne - 1) p = lmax(lmax(p - delta, 0), lmax(tna, MIN_PERIOD));
    end
    for (longint i = 0; i < cn; i++) per.push_back(lmax(tna, MIN_PERIOD));
    for (longint i = 0; i < ne; i++) begin
      per.push_back(p);
      p = (p + delta > top) ? top : p + delta;
    end
    t = e0 + 1;
    foreach (per[i]) begin
      exp_q.push_back('{is_fin: 1'b0, cyc: int'(t), sd: i + 1, d: d});
      t += per[i];
    end
    exp_q.push_back('{is_fin: 1'b1, cyc: int'(t), sd: n, d: d});
    total = t - e0;
  endtask

  task automatic scramble_params();
    for (int i = 0; i < 5; i++) bus.params[i] = $urandom_range(0, 200);
    bus.dir = $urandom_range(0, 1);
  endtask

  // Issue one move; when early is set, start is raised in the finish cycle and held
  task automatic start_move(input longint n, input longint nn, input longint t0,
                            input longint tna, input longint delta, input bit d,
                            input bit early, output int unsigned e0, output longint total);
    if (!(early && last_finished)) begin
      @(negedge clk); #1;
    end
    bus.params[0] = 32'(n);  bus.params[1] = 32'(nn); bus.params[2] = 32'(t0);
    bus.params[3] = 32'(tna); bus.params[4] = 32'(delta);
    bus.dir = d;
    bus.start = 1'b1;
    e0 = (early && last_finished) ? cyc + 2 : cyc + 1;
    push_expected(n, nn, t0, tna, delta, d, e0, total);
    if (early && last_finished) begin
      @(negedge clk); #1;
    end
    @(negedge clk); #1;
    bus.start = 1'b0;
    scramble_params();
    last_finished = 1'b0;
    if (n > 0) begin
      // start pulse mid-move with different parameters must be ignored
      repeat (2) begin @(negedge clk); #1; end
      bus.start = 1'b1;
      @(negedge clk); #1;
      bus.start = 1'b0;
    end
  endtask

  task automatic wait_move(input longint total);
    longint t = 0;
    while (exp_q.size() != 0 && t < total + 40) begin
      @(negedge clk); #1;
      t++;
    end
    chk("move_completes_in_time", exp_q.size(), 0);
    exp_q.delete();
    last_finished = 1'b1;
  endtask

  task automatic run_move(input longint n, input longint nn, input longint t0,
                          input longint tna, input longint delta, input bit d, input bit early);
    int unsigned e0;
    longint total;
    start_move(n, nn, t0, tna, delta, d, early, e0, total);
    $display("move N=%0d nn=%0d t0=%0d tna=%0d delta=%0d dir=%0d start_edge=%0d expected_finish=%0d",
             n, nn, t0, tna, delta, d, e0, e0 + total);
    wait_move(total);
  endtask

  // Monitor: pops one expected event per observed step rise or finish cycle
  bit prev_step = 1'b0;
  int hi_cnt = 0;

  task automatic take_event(input bit is_fin);
    item_t it;
    if (exp_q.size() == 0) begin
      chk(is_fin ? "unexpected_finish" : "unexpected_step", 1, 0);
    end else begin
      it = exp_q.pop_front();
      chk("event_kind", is_fin, it.is_fin);
      chk(is_fin ? "finish_cycle" : "step_cycle", cyc, it.cyc);
      chk("steps_done", bus.steps_done, it.sd);
      chk("dir_out", bus.dir_out, it.d);
      chk("busy", bus.busy, is_fin ? 0 : 1);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      prev_step = 1'b0;
      hi_cnt    = 0;
    end else begin
      if (bus.step && !prev_step) take_event(1'b0);
      if (bus.finish) take_event(1'b1);
      if (bus.step) hi_cnt++;
      else if (prev_step) begin
        chk("pulse_width", hi_cnt, PULSE_W);
        hi_cnt = 0;
      end
      prev_step = bus.step;
    end
  end

  initial begin
    int unsigned e0;
    longint total;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.dir = 1'b0;
    for (int i = 0; i < 5; i++) bus.params[i] = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_step", bus.step, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_finish", bus.finish, 0);
    chk("reset_dir_out", bus.dir_out, 0);
    chk("reset_steps_done", bus.steps_done, 0);
    reset = 1'b0;

    // Directed profiles
    run_move(6, 2, 100, 60, 20, 1'b1, 1'b0);
    run_move(0, 3, 40, 20, 5, 1'b0, 1'b1);
    run_move(3, 5, 50, 20, 10, 1'b1, 1'b1);
    run_move(6, 3, 100, 20, 50, 1'b0, 1'b0);
    run_move(2, 0, 3, 2, 1, 1'b1, 1'b1);
    run_move(5, 2, 40, 10, 64'hFFFF_FF00, 1'b0, 1'b0);
    run_move(4, 2, 10, 50, 3, 1'b1, 1'b1);

    // Reset mid-move, then replay the full first profile
    start_move(6, 2, 100, 60, 20, 1'b1, 1'b0, e0, total);
    while (cyc < e0 + 149) begin @(negedge clk); #1; end
    reset = 1'b1;
    @(negedge clk); #1;
    $display("reset applied at edge %0d of move", cyc - e0);
    chk("midreset_step", bus.step, 0);
    chk("midreset_busy", bus.busy, 0);
    chk("midreset_finish", bus.finish, 0);
    chk("midreset_steps_done", bus.steps_done, 0);
    exp_q.delete();
    reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("no_finish_after_reset", bus.finish, 0);
    last_finished = 1'b0;
    run_move(6, 2, 100, 60, 20, 1'b1, 1'b0);

    // Randomized moves
    for (int i = 0; i < 25; i++) begin
      longint n, nn, t0, tna, delta;
      n     = $urandom_range(0, 10);
      nn    = $urandom_range(0, 6);
      t0    = $urandom_range(0, 60);
      tna   = $urandom_range(0, 60);
      delta = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFF0 : longint'($urandom_range(0, 40));
      run_move(n, nn, t0, tna, delta, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
